// File: rtl/shadow_stack_monitor.sv
// shadow_stack_monitor
//   Return-address shadow stack for the branch unit's resolved call/return
//   stream. A resolved call pushes its link address. A resolved return pops
//   the top entry and compares it with the actual return target. A mismatch
//   latches an alarm and raises a crash request, which the branch unit uses to
//   force the next JAL/JALR target to zero.
//
//   Optional macro SHSTK_RA_MASK_EN: the incoming addresses use the branch
//   unit's masked encoding. They are decoded before they are stored or
//   compared, so dbg_data_o shows decoded values.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   resolve_valid_i  a resolved control-flow instruction is presented
//   is_call_i        the instruction is a call (rd==x1)
//   is_ret_i         the instruction is a return (rd==x0, rs1==x1)
//   link_addr_i      link address that is pushed on a call
//   ret_target_i     resolved target of a return
//   clear_i          clears the stack pointer, occupancy and all flags; storage is kept
//   en_crash_i       allows crash_o to follow alarm_o
//   dbg_index_i      debug read slot
//   dbg_data_o       raw storage slot dbg_index_i (combinational read)
//   depth_o          current occupancy, 0..DEPTH
//   violation_o      one-cycle pulse, one cycle after a mismatching event
//   alarm_o          sticky mismatch flag
//   overflow_o       sticky flag: a push happened while the stack was full
//   underflow_cnt_o  returns seen while the stack was empty, saturates at 255
//   crash_o          alarm_o & en_crash_i
//
// state | meaning
// ------+--------------------------------------------------------------
// MON   | events accepted, stack tracks calls and returns
// ALARM | a mismatch was seen; stack frozen until clear_i or rst_i

module shadow_stack_monitor #(
  parameter int DEPTH = 16,
  parameter int AW    = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             resolve_valid_i,
  input  logic             is_call_i,
  input  logic             is_ret_i,
  input  logic [AW-1:0]    link_addr_i,
  input  logic [AW-1:0]    ret_target_i,
  input  logic             clear_i,
  input  logic             en_crash_i,
  input  logic [PTR_W-1:0] dbg_index_i,
  output logic [AW-1:0]    dbg_data_o,
  output logic [PTR_W:0]   depth_o,
  output logic             violation_o,
  output logic             alarm_o,
  output logic             overflow_o,
  output logic [7:0]       underflow_cnt_o,
  output logic             crash_o
);

  localparam logic ST_MON   = 1'b0;
  localparam logic ST_ALARM = 1'b1;

  logic [AW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] sp;
  logic [PTR_W:0]   depth;
  logic             state;
  logic             violation;
  logic             alarm;
  logic             overflow;
  logic [7:0]       uf_cnt;

  logic [AW-1:0]    link;
  logic [AW-1:0]    target;

`ifdef SHSTK_RA_MASK_EN
  assign link   = {{(AW-31){1'b0}}, link_addr_i[30:0]  ^ 31'h73fa06c2};
  assign target = {{(AW-31){1'b0}}, ret_target_i[30:0] ^ 31'h73fa06c2};
`else
  assign link   = link_addr_i;
  assign target = ret_target_i;
`endif

  logic [PTR_W-1:0] sp_inc;
  logic [PTR_W-1:0] sp_dec;
  logic [AW-1:0]    top;
  logic             empty;
  logic             full;
  logic             accept;
  logic             do_push;
  logic             do_swap;
  logic             do_pop;
  logic             do_uf;
  logic             mismatch;
  logic             mem_we;
  logic [PTR_W-1:0] mem_wa;

  assign sp_inc = sp + PTR_W'(1);
  assign sp_dec = sp - PTR_W'(1);
  assign top    = mem[sp_dec];
  assign empty  = (depth == '0);
  assign full   = (depth == (PTR_W+1)'(DEPTH));

  // Reset and clear take priority over any event in the same cycle.
  assign accept = resolve_valid_i && (state == ST_MON) && !clear_i && !rst_i;

  // A swap (call and return together) on an empty stack becomes a plain push.
  assign do_push = accept && is_call_i && (!is_ret_i || empty);
  assign do_swap = accept && is_call_i && is_ret_i && !empty;
  assign do_pop  = accept && is_ret_i && !is_call_i && !empty;
  assign do_uf   = accept && is_ret_i && !is_call_i && empty;

  assign mismatch = (do_swap || do_pop) && (top != target);

  assign mem_we = do_push || do_swap;
  assign mem_wa = do_swap ? sp_dec : sp;

  // Storage has no reset: after a reset or clear, stale entries stay readable
  // through the debug port.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_wa] <= link;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      sp        <= '0;
      depth     <= '0;
      state     <= ST_MON;
      violation <= 1'b0;
      alarm     <= 1'b0;
      overflow  <= 1'b0;
      uf_cnt    <= '0;
    end else begin
      violation <= mismatch;
      if (mismatch) begin
        state <= ST_ALARM;
        alarm <= 1'b1;
      end
      if (do_push) begin
        sp <= sp_inc;
        // A push onto a full stack overwrites the oldest entry.
        if (full) begin
          overflow <= 1'b1;
        end else begin
          depth <= depth + (PTR_W+1)'(1);
        end
      end
      if (do_pop) begin
        sp    <= sp_dec;
        depth <= depth - (PTR_W+1)'(1);
      end
      if (do_uf && (uf_cnt != 8'hff)) begin
        uf_cnt <= uf_cnt + 8'd1;
      end
    end
  end

  assign dbg_data_o      = mem[dbg_index_i];
  assign depth_o         = depth;
  assign violation_o     = violation;
  assign alarm_o         = alarm;
  assign overflow_o      = overflow;
  assign underflow_cnt_o = uf_cnt;
  assign crash_o         = alarm & en_crash_i;

endmodule

// File: tb/tb_shadow_stack_monitor.sv
module tb_shadow_stack_monitor;

  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int PTR_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             resolve_valid_i = 1'b0;
  logic             is_call_i = 1'b0;
  logic             is_ret_i = 1'b0;
  logic [AW-1:0]    link_addr_i = '0;
  logic [AW-1:0]    ret_target_i = '0;
  logic             clear_i = 1'b0;
  logic             en_crash_i = 1'b0;
  logic [PTR_W-1:0] dbg_index_i = '0;
  logic [AW-1:0]    dbg_data_o;
  logic [PTR_W:0]   depth_o;
  logic             violation_o;
  logic             alarm_o;
  logic             overflow_o;
  logic [7:0]       underflow_cnt_o;
  logic             crash_o;

  shadow_stack_monitor #(.DEPTH(DEPTH), .AW(AW), .PTR_W(PTR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .resolve_valid_i(resolve_valid_i),
    .is_call_i(is_call_i), .is_ret_i(is_ret_i), .link_addr_i(link_addr_i),
    .ret_target_i(ret_target_i), .clear_i(clear_i), .en_crash_i(en_crash_i),
    .dbg_index_i(dbg_index_i), .dbg_data_o(dbg_data_o), .depth_o(depth_o),
    .violation_o(violation_o), .alarm_o(alarm_o), .overflow_o(overflow_o),
    .underflow_cnt_o(underflow_cnt_o), .crash_o(crash_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // reference model: the stack as a bounded queue of decoded addresses
  logic [31:0] stk[$];
  logic        m_alarm = 1'b0;
  logic        m_ovf   = 1'b0;
  int          m_uf    = 0;
  logic        m_viol  = 1'b0;

  function automatic logic [31:0] dec(input logic [31:0] x);
`ifdef SHSTK_RA_MASK_EN
    return {1'b0, x[30:0] ^ 31'h73fa06c2};
`else
    return x;
`endif
  endfunction

  // raw bus value that decodes to the given address
  function automatic logic [31:0] enc(input logic [31:0] x);
`ifdef SHSTK_RA_MASK_EN
    logic [31:0] r;
    r = $urandom;
    return {r[31], x[30:0] ^ 31'h73fa06c2};
`else
    return x;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic v, c, r, input logic [31:0] la, ta,
                            input logic clr, rs);
    logic [31:0] l, t, top;
    l = dec(la);
    t = dec(ta);
    m_viol = 1'b0;
    if (rs || clr) begin
      stk.delete();
      m_alarm = 1'b0;
      m_ovf   = 1'b0;
      m_uf    = 0;
    end else if (v && !m_alarm) begin
      if (c && r) begin
        if (stk.size() > 0) begin
          top = stk.pop_back();
          if (top != t) m_viol = 1'b1;
          stk.push_back(l);
        end else begin
          stk.push_back(l);
        end
      end else if (c) begin
        if (stk.size() == DEPTH) begin
          void'(stk.pop_front());
          m_ovf = 1'b1;
        end
        stk.push_back(l);
      end else if (r) begin
        if (stk.size() > 0) begin
          top = stk.pop_back();
          if (top != t) m_viol = 1'b1;
        end else if (m_uf < 255) begin
          m_uf++;
        end
      end
      if (m_viol) m_alarm = 1'b1;
    end
  endtask

  task automatic step(input logic v, c, r, input logic [31:0] la, ta,
                      input logic clr, rs);
    resolve_valid_i = v;
    is_call_i       = c;
    is_ret_i        = r;
    link_addr_i     = la;
    ret_target_i    = ta;
    clear_i         = clr;
    rst_i           = rs;
    @(posedge clk_i);
    #1;
    model_step(v, c, r, la, ta, clr, rs);
    check("depth",     32'(depth_o),         32'(stk.size()));
    check("violation", 32'(violation_o),     32'(m_viol));
    check("alarm",     32'(alarm_o),         32'(m_alarm));
    check("overflow",  32'(overflow_o),      32'(m_ovf));
    check("underflow", 32'(underflow_cnt_o), 32'(m_uf));
    check("crash",     32'(crash_o),         32'(m_alarm & en_crash_i));
  endtask

  task automatic call(input logic [31:0] a);
    step(1'b1, 1'b1, 1'b0, a, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic ret(input logic [31:0] a);
    step(1'b1, 1'b0, 1'b1, 32'h0, a, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    en_crash_i = 1'b1;
    do_reset();
    check("reset_depth", 32'(depth_o), 32'd0);
    check("reset_alarm", 32'(alarm_o), 32'd0);

    // matching call/return
    call(enc(32'h80000104));
    check("match_depth1", 32'(depth_o), 32'd1);
    ret(enc(32'h80000104));
    check("match_depth0", 32'(depth_o), 32'd0);
    check("match_noviol", 32'(violation_o), 32'd0);

    // mismatching return raises the alarm
    call(enc(32'h80000104));
    ret(enc(32'h80000200));
    check("mis_viol", 32'(violation_o), 32'd1);
    check("mis_crash", 32'(crash_o), 32'd1);
    idle();
    check("viol_one_cycle", 32'(violation_o), 32'd0);
    call(enc(32'h12345678));
    check("alarm_frozen", 32'(depth_o), 32'd0);
    en_crash_i = 1'b0;
    #1;
    check("crash_comb_drop", 32'(crash_o), 32'd0);
    en_crash_i = 1'b1;
    do_clear();
    check("clear_alarm", 32'(alarm_o), 32'd0);

    // overflow with wrap; stack starts at slot 0 after the clear
    for (int k = 0; k <= 16; k++) call(enc(32'h1000 + 32'(4 * k)));
    check("ovf_flag", 32'(overflow_o), 32'd1);
    check("ovf_depth", 32'(depth_o), 32'd16);
    dbg_index_i = 4'd0;
    #1;
    check("dbg_slot0", dbg_data_o, dec(enc(32'h1040)));
    dbg_index_i = 4'd1;
    #1;
    check("dbg_slot1", dbg_data_o, dec(enc(32'h1004)));
    for (int k = 16; k >= 1; k--) ret(enc(32'h1000 + 32'(4 * k)));
    check("ovf_noalarm", 32'(alarm_o), 32'd0);
    ret(enc(32'h1000));
    check("ovf_underflow", 32'(underflow_cnt_o), 32'd1);

    // underflow saturation
    do_reset();
    ret(32'h0);
    check("uf_one", 32'(underflow_cnt_o), 32'd1);
    for (int i = 0; i < 299; i++) ret(32'h0);
    check("uf_sat", 32'(underflow_cnt_o), 32'd255);

    // clear beats a simultaneous call; reset empties a held stack
    do_reset();
    step(1'b1, 1'b1, 1'b0, enc(32'h2000), 32'h0, 1'b1, 1'b0);
    check("clear_vs_call", 32'(depth_o), 32'd0);
    call(enc(32'h2000));
    call(enc(32'h2004));
    call(enc(32'h2008));
    check("held3", 32'(depth_o), 32'd3);
    do_reset();
    check("rst_depth", 32'(depth_o), 32'd0);
    ret(32'h0);
    check("rst_then_uf", 32'(underflow_cnt_o), 32'd1);

    // swap: compare top, then replace it
    do_reset();
    step(1'b1, 1'b1, 1'b1, enc(32'h3000), enc(32'h9999), 1'b0, 1'b0);
    check("swap_empty_push", 32'(depth_o), 32'd1);
    step(1'b1, 1'b1, 1'b1, enc(32'h3004), enc(32'h3000), 1'b0, 1'b0);
    check("swap_depth", 32'(depth_o), 32'd1);
    ret(enc(32'h3004));
    check("swap_match", 32'(alarm_o), 32'd0);

`ifdef SHSTK_RA_MASK_EN
    do_reset();
    call(32'h73fa07c6);
    dbg_index_i = 4'd0;
    #1;
    check("mask_dbg", dbg_data_o, 32'h00000104);
    ret(32'hf3fa07c6);
    check("mask_noviol", 32'(violation_o), 32'd0);
`endif

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int          r;
      logic        v, c, rr, clr;
      logic [31:0] la, ta;
      r   = int'($urandom_range(0, 99));
      v   = ($urandom_range(0, 9) != 0);
      clr = (r < 2) || (m_alarm && $urandom_range(0, 7) == 0);
      c   = 1'b0;
      rr  = 1'b0;
      if (r < 47) c = 1'b1;
      else if (r < 87) rr = 1'b1;
      else if (r < 93) begin c = 1'b1; rr = 1'b1; end
      la = $urandom;
      if (stk.size() > 0 && $urandom_range(0, 24) != 0) ta = enc(stk[$]);
      else ta = $urandom;
      en_crash_i = ($urandom_range(0, 3) != 0);
      step(v, c, rr, la, ta, clr, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
